servo_status_rx: RTL and testbench
==================================

SERVO_STATUS_RX -- requirements
Module: servo_status_rx

Interface
REQ-001 Parameter MAX_PARAM, default 4: maximum status parameter bytes accepted per packet.
REQ-002 Parameter TIMEOUT_CYC, default 50000: idle cycles allowed between bytes of one packet (1 ms at 50 MHz).
REQ-003 sys_clk  input  1  sole clock; all logic on rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-007 rsp_valid  output  1  one-cycle pulse; a good status packet was decoded.
REQ-008 rsp_id  output  8  servo ID of the last good packet.
REQ-009 rsp_err  output  8  servo error byte of the last good packet.
REQ-010 rsp_param  output  8*MAX_PARAM  parameters; first received byte in [7:0], unused bytes zero.
REQ-011 rsp_nparam  output  3  parameter count of the last good packet.
REQ-012 chk_fail  output  1  one-cycle pulse; checksum mismatch.
REQ-013 len_fail  output  1  one-cycle pulse; LEN byte out of range.
REQ-014 timeout  output  1  one-cycle pulse; packet abandoned due to inter-byte gap.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 Packet format SHALL be FF FF ID LEN ERR P0..Pn-1 CHK, with n = LEN-2.
REQ-017 FSM states SHALL be IDLE, HDR2, GET_ID, GET_LEN, GET_ERR, GET_PARAM, GET_CHK; it advances only on cycles with rx_valid=1.
REQ-018 IDLE: byte FF -> HDR2; any other byte -> stay in IDLE.
REQ-019 HDR2: FF -> GET_ID; any other byte -> IDLE.
REQ-020 GET_ID: FF -> remain in GET_ID (extra header byte); any other byte -> latch ID, sum=ID, go to GET_LEN.
REQ-021 GET_LEN: 2 <= LEN <= MAX_PARAM+2 -> sum+=LEN, go to GET_ERR; otherwise pulse len_fail next cycle and go to IDLE.
REQ-022 GET_ERR: latch ERR, sum+=ERR; if LEN==2 go to GET_CHK, else go to GET_PARAM.
REQ-023 GET_PARAM: store the byte at index k (k=0..n-1), sum+=byte; after byte n-1 go to GET_CHK.
REQ-024 The sum SHALL be 8-bit and wrap modulo 256; the expected checksum is ~sum.
REQ-025 GET_CHK: if the byte equals ~sum, then on the next cycle update rsp_id, rsp_err, rsp_param (unused bytes zeroed) and rsp_nparam, and pulse rsp_valid for 1 cycle; otherwise pulse chk_fail and leave the rsp_* outputs unchanged. Both cases go to IDLE.
REQ-026 Latency SHALL be exactly 1 cycle from the rx_valid of the CHK byte to rsp_valid or chk_fail.
REQ-027 rsp_id, rsp_err, rsp_param and rsp_nparam SHALL be registered and hold their values until the next good packet.
REQ-028 Gap counter: cleared on every rx_valid and held at zero in IDLE. When it reaches TIMEOUT_CYC-1 outside IDLE, pulse timeout and go to IDLE.
REQ-029 If rx_valid coincides with gap-counter expiry, the byte is processed and no timeout occurs.
REQ-030 A byte arriving in the cycle a packet completes SHALL be evaluated from IDLE, so back-to-back packets are decoded.
REQ-031 At most one of rsp_valid, chk_fail, len_fail, timeout SHALL be high in any cycle.

Reset
REQ-032 While sys_rst=1: FSM=IDLE; sum, gap counter, all outputs and the parameter buffer are 0.
REQ-033 Reset asserted mid-packet SHALL discard the partial packet with no pulses; decoding restarts from IDLE once reset releases.

Verification
REQ-034 FF FF 01 06 00 E8 03 DC 05 2C -> rsp_valid 1 cycle after 2C; rsp_id=01, rsp_err=00, rsp_param=05DC03E8, rsp_nparam=4.
REQ-035 Same packet with CHK=2D -> chk_fail pulse; rsp_valid stays 0; rsp_* outputs keep their previous values.
REQ-036 FF FF FF 01 02 00 FC -> rsp_valid; rsp_id=01, rsp_nparam=0, rsp_param=0.
REQ-037 FF FF 01 07 -> len_fail pulse 1 cycle later; busy=0; following packet from REQ-034 decodes correctly.
REQ-038 FF FF 01 then no bytes -> timeout pulse TIMEOUT_CYC cycles after the 01 strobe; a byte on the expiry cycle suppresses the timeout.
REQ-039 sys_rst pulsed after FF FF 01 06 -> all outputs 0, no pulses; packet from REQ-034 then decodes normally.

Source files
------------

// File: rtl/servo_status_rx.sv
// servo_status_rx: decodes servo status packets (FF FF ID LEN ERR P0..Pn-1 CHK) from a UART byte stream.
// Ports:
//   sys_clk, sys_rst         clock and asynchronous active-high reset
//   rx_data, rx_valid        received byte and its one-cycle strobe
//   rsp_valid                one-cycle pulse when a good packet has been decoded
//   rsp_id, rsp_err          ID and error byte of the last good packet
//   rsp_param, rsp_nparam    parameters (first byte in [7:0], unused bytes zero) and their count
//   chk_fail, len_fail       one-cycle pulses for checksum mismatch / LEN out of range
//   timeout                  one-cycle pulse when a packet is abandoned on an inter-byte gap
//   busy                     high whenever a packet is in progress
module servo_status_rx #(
    parameter int MAX_PARAM   = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rsp_valid,
    output logic [7:0]             rsp_id,
    output logic [7:0]             rsp_err,
    output logic [8*MAX_PARAM-1:0] rsp_param,
    output logic [2:0]             rsp_nparam,
    output logic                   chk_fail,
    output logic                   len_fail,
    output logic                   timeout,
    output logic                   busy
);
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] LEN_MAX = 8'(MAX_PARAM + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, HDR2, GET_ID, GET_LEN, GET_ERR, GET_PARAM, GET_CHK} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             sum_q, sum_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [7:0]             id_q, id_d, err_q, err_d;
    logic [2:0]             n_q, n_d, k_q, k_d;
    logic [8*MAX_PARAM-1:0] pbuf_q, pbuf_d, masked;
    logic                   rsp_valid_q, rsp_valid_d, chk_fail_q, chk_fail_d;
    logic                   len_fail_q, len_fail_d, timeout_q, timeout_d;
    logic [7:0]             rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
    logic [8*MAX_PARAM-1:0] rsp_param_q, rsp_param_d;
    logic [2:0]             rsp_nparam_q, rsp_nparam_d;
    logic                   expire;

    // A byte on the expiry cycle wins over the timeout.
    assign expire = (state_q != IDLE) && !rx_valid && (gap_q == GAP_LAST);

    always_comb begin
        masked = '0;
        for (int i = 0; i < MAX_PARAM; i++)
            masked[i*8 +: 8] = (i < int'(n_q)) ? pbuf_q[i*8 +: 8] : 8'h00;
    end

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        gap_d        = (state_q == IDLE || rx_valid) ? '0 : gap_q + 1'b1;
        id_d         = id_q;
        err_d        = err_q;
        n_d          = n_q;
        k_d          = k_q;
        pbuf_d       = pbuf_q;
        rsp_valid_d  = 1'b0;
        chk_fail_d   = 1'b0;
        len_fail_d   = 1'b0;
        timeout_d    = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        rsp_param_d  = rsp_param_q;
        rsp_nparam_d = rsp_nparam_q;
        if (expire) begin
            state_d   = IDLE;
            gap_d     = '0;
            timeout_d = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                IDLE:   state_d = (rx_data == 8'hFF) ? HDR2 : IDLE;
                HDR2:   state_d = (rx_data == 8'hFF) ? GET_ID : IDLE;
                GET_ID: if (rx_data != 8'hFF) begin
                    id_d    = rx_data;
                    sum_d   = rx_data;
                    state_d = GET_LEN;
                end
                GET_LEN: if (rx_data >= 8'd2 && rx_data <= LEN_MAX) begin
                    sum_d   = sum_q + rx_data;
                    n_d     = 3'(rx_data - 8'd2);
                    state_d = GET_ERR;
                end else begin
                    len_fail_d = 1'b1;
                    state_d    = IDLE;
                end
                GET_ERR: begin
                    err_d   = rx_data;
                    sum_d   = sum_q + rx_data;
                    k_d     = '0;
                    state_d = (n_q == 3'd0) ? GET_CHK : GET_PARAM;
                end
                GET_PARAM: begin
                    pbuf_d[{k_q, 3'b000} +: 8] = rx_data;
                    sum_d   = sum_q + rx_data;
                    k_d     = k_q + 3'd1;
                    state_d = (k_q == n_q - 3'd1) ? GET_CHK : GET_PARAM;
                end
                GET_CHK: begin
                    if (rx_data == ~sum_q) begin
                        rsp_valid_d  = 1'b1;
                        rsp_id_d     = id_q;
                        rsp_err_d    = err_q;
                        rsp_param_d  = masked;
                        rsp_nparam_d = n_q;
                    end else begin
                        chk_fail_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            sum_q        <= '0;
            gap_q        <= '0;
            id_q         <= '0;
            err_q        <= '0;
            n_q          <= '0;
            k_q          <= '0;
            pbuf_q       <= '0;
            rsp_valid_q  <= 1'b0;
            chk_fail_q   <= 1'b0;
            len_fail_q   <= 1'b0;
            timeout_q    <= 1'b0;
            rsp_id_q     <= '0;
            rsp_err_q    <= '0;
            rsp_param_q  <= '0;
            rsp_nparam_q <= '0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            gap_q        <= gap_d;
            id_q         <= id_d;
            err_q        <= err_d;
            n_q          <= n_d;
            k_q          <= k_d;
            pbuf_q       <= pbuf_d;
            rsp_valid_q  <= rsp_valid_d;
            chk_fail_q   <= chk_fail_d;
            len_fail_q   <= len_fail_d;
            timeout_q    <= timeout_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_param_q  <= rsp_param_d;
            rsp_nparam_q <= rsp_nparam_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign chk_fail   = chk_fail_q;
    assign len_fail   = len_fail_q;
    assign timeout    = timeout_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_param  = rsp_param_q;
    assign rsp_nparam = rsp_nparam_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_servo_status_rx.sv
// tb_servo_status_rx: randomized and directed checks of servo_status_rx against a packet-level model.
module tb_servo_status_rx;
    localparam int MP = 4;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rsp_valid, chk_fail, len_fail, timeout, busy;
    logic [7:0]    rsp_id, rsp_err;
    logic [8*MP-1:0] rsp_param;
    logic [2:0]    rsp_nparam;

    int checks = 0, passed = 0, npulse = 0, multi = 0;
    logic [7:0]  e_id = 8'h00, e_err = 8'h00;
    logic [31:0] e_par = 32'h0;
    logic [2:0]  e_n = 3'd0;

    servo_status_rx #(.MAX_PARAM(MP), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(clk), .sys_rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_param(rsp_param),
        .rsp_nparam(rsp_nparam), .chk_fail(chk_fail), .len_fail(len_fail),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        int s;
        s = int'(rsp_valid) + int'(chk_fail) + int'(len_fail) + int'(timeout);
        npulse += s;
        if (s > 1) multi++;
    end

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one packet built from its fields and checks the outcome against the model.
    task automatic run_pkt(input logic [7:0] id, input logic [7:0] err, input int n,
                           input logic [31:0] par, input logic bad, input int xff, input int gap);
        logic [7:0] s, c;
        logic [31:0] m;
        m = 32'h0;
        s = id + 8'(n + 2) + err;
        for (int i = 0; i < n; i++) begin
            m[i*8 +: 8] = par[i*8 +: 8];
            s += par[i*8 +: 8];
        end
        c = ~s;
        if (bad) c ^= 8'($urandom_range(1, 255));
        put(8'hFF); idle(gap);
        put(8'hFF); idle(gap);
        for (int i = 0; i < xff; i++) begin put(8'hFF); idle(gap); end
        put(id); idle(gap);
        put(8'(n + 2)); idle(gap);
        put(err); idle(gap);
        for (int i = 0; i < n; i++) begin put(par[i*8 +: 8]); idle(gap); end
        put(c);
        if (!bad) begin
            e_id = id; e_err = err; e_n = 3'(n); e_par = m;
        end
        checks++; if (rsp_valid !== !bad) $display("FAIL pkt_valid got %b want %b", rsp_valid, !bad); else passed++;
        checks++; if (chk_fail !== bad) $display("FAIL pkt_chk_fail got %b want %b", chk_fail, bad); else passed++;
        checks++; if (rsp_id !== e_id) $display("FAIL pkt_id got %h want %h", rsp_id, e_id); else passed++;
        checks++; if (rsp_err !== e_err) $display("FAIL pkt_err got %h want %h", rsp_err, e_err); else passed++;
        checks++; if (rsp_param !== e_par) $display("FAIL pkt_param got %h want %h", rsp_param, e_par); else passed++;
        checks++; if (rsp_nparam !== e_n) $display("FAIL pkt_nparam got %0d want %0d", rsp_nparam, e_n); else passed++;
    endtask

    task automatic test_reset();
        idle(2);
        checks++; if ({rsp_valid, chk_fail, len_fail, timeout, busy} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {rsp_valid, chk_fail, len_fail, timeout, busy}); else passed++;
        checks++; if ({rsp_id, rsp_err, rsp_param, rsp_nparam} !== '0) $display("FAIL reset_data got %h want 0", {rsp_id, rsp_err, rsp_param, rsp_nparam}); else passed++;
        rst = 1'b0;
        idle(2);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_vector();
        logic [7:0] v [10];
        v = '{8'hFF, 8'hFF, 8'h01, 8'h06, 8'h00, 8'hE8, 8'h03, 8'hDC, 8'h05, 8'h2C};
        for (int i = 0; i < 10; i++) put(v[i]);
        checks++; if (rsp_valid !== 1'b1) $display("FAIL vec_valid got %b want 1", rsp_valid); else passed++;
        checks++; if (rsp_id !== 8'h01 || rsp_err !== 8'h00) $display("FAIL vec_id_err got %h/%h want 01/00", rsp_id, rsp_err); else passed++;
        checks++; if (rsp_param !== 32'h05DC03E8) $display("FAIL vec_param got %h want 05dc03e8", rsp_param); else passed++;
        checks++; if (rsp_nparam !== 3'd4) $display("FAIL vec_nparam got %0d want 4", rsp_nparam); else passed++;
        idle(1);
        checks++; if (rsp_valid !== 1'b0) $display("FAIL vec_pulse_width got %b want 0", rsp_valid); else passed++;
        e_id = 8'h01; e_err = 8'h00; e_par = 32'h05DC03E8; e_n = 3'd4;
        v[9] = 8'h2D;
        for (int i = 0; i < 10; i++) put(v[i]);
        checks++; if (chk_fail !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL bad_chk got chk_fail=%b valid=%b want 1/0", chk_fail, rsp_valid); else passed++;
        checks++; if (rsp_param !== 32'h05DC03E8 || rsp_nparam !== 3'd4) $display("FAIL bad_chk_hold got %h/%0d want 05dc03e8/4", rsp_param, rsp_nparam); else passed++;
        idle(1);
        checks++; if (chk_fail !== 1'b0) $display("FAIL bad_chk_width got %b want 0", chk_fail); else passed++;
    endtask

    task automatic test_zero_param();
        logic [7:0] v [7];
        v = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
        for (int i = 0; i < 7; i++) put(v[i]);
        checks++; if (rsp_valid !== 1'b1) $display("FAIL zero_valid got %b want 1", rsp_valid); else passed++;
        checks++; if (rsp_id !== 8'h01 || rsp_nparam !== 3'd0 || rsp_param !== 32'h0) $display("FAIL zero_data got %h/%0d/%h want 01/0/0", rsp_id, rsp_nparam, rsp_param); else passed++;
        e_id = 8'h01; e_err = 8'h00; e_par = 32'h0; e_n = 3'd0;
        idle(1);
    endtask

    task automatic test_len_fail();
        logic [7:0] bad_len [3];
        bad_len = '{8'h07, 8'h01, 8'h00};
        for (int j = 0; j < 3; j++) begin
            put(8'hFF); put(8'hFF); put(8'h01); put(bad_len[j]);
            checks++; if (len_fail !== 1'b1 || busy !== 1'b0) $display("FAIL len_fail[%h] got len_fail=%b busy=%b want 1/0", bad_len[j], len_fail, busy); else passed++;
            idle(1);
            checks++; if (len_fail !== 1'b0) $display("FAIL len_fail_width got %b want 0", len_fail); else passed++;
        end
        run_pkt(8'h01, 8'h00, 4, 32'h05DC03E8, 1'b0, 0, 0);
        idle(1);
    endtask

    task automatic test_timeout();
        int hit;
        hit = 0;
        put(8'hFF); put(8'hFF); put(8'h01);
        for (int c = 1; c <= TO + 5 && hit == 0; c++) begin
            if (timeout === 1'b1) hit = c - 1;
            else @(negedge clk);
        end
        if (hit == 0 && timeout === 1'b1) hit = TO + 5;
        checks++; if (hit != TO) $display("FAIL timeout_cycles got %0d want %0d", hit, TO); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL timeout_busy got %b want 0", busy); else passed++;
        idle(2);
        put(8'hFF); put(8'hFF); put(8'h01);
        idle(TO - 1);
        put(8'h06);
        checks++; if (timeout !== 1'b0 || busy !== 1'b1) $display("FAIL timeout_suppress got timeout=%b busy=%b want 0/1", timeout, busy); else passed++;
        put(8'h00); put(8'hE8); put(8'h03); put(8'hDC); put(8'h05); put(8'h2C);
        checks++; if (rsp_valid !== 1'b1 || rsp_param !== 32'h05DC03E8) $display("FAIL timeout_resume got valid=%b param=%h want 1/05dc03e8", rsp_valid, rsp_param); else passed++;
        e_id = 8'h01; e_err = 8'h00; e_par = 32'h05DC03E8; e_n = 3'd4;
        idle(1);
    endtask

    task automatic test_reset_mid();
        int p0;
        put(8'hFF); put(8'hFF); put(8'h01); put(8'h06);
        #2 rst = 1'b1;
        p0 = npulse;
        idle(2);
        checks++; if ({rsp_valid, chk_fail, len_fail, timeout, busy} !== 5'b0) $display("FAIL rstmid_flags got %b want 00000", {rsp_valid, chk_fail, len_fail, timeout, busy}); else passed++;
        checks++; if ({rsp_id, rsp_err, rsp_param, rsp_nparam} !== '0) $display("FAIL rstmid_data got %h want 0", {rsp_id, rsp_err, rsp_param, rsp_nparam}); else passed++;
        rst = 1'b0;
        e_id = 8'h00; e_err = 8'h00; e_par = 32'h0; e_n = 3'd0;
        idle(2);
        checks++; if (npulse != p0) $display("FAIL rstmid_pulses got %0d want %0d", npulse, p0); else passed++;
        run_pkt(8'h01, 8'h00, 4, 32'h05DC03E8, 1'b0, 0, 0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        run_pkt(8'h11, 8'h20, 2, 32'h0000BEEF, 1'b0, 0, 0);
        run_pkt(8'h22, 8'h00, 3, 32'h00123456, 1'b0, 0, 0);
        run_pkt(8'h33, 8'h01, 1, 32'h0000007F, 1'b1, 0, 0);
        run_pkt(8'h44, 8'h02, 0, 32'h0, 1'b0, 0, 0);
        idle(1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 40; p++) begin
            int pre;
            pre = $urandom_range(0, 2);
            for (int i = 0; i < pre; i++) put(8'($urandom_range(0, 254)));
            run_pkt(8'($urandom_range(0, 254)), 8'($urandom), $urandom_range(0, MP), $urandom,
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 2), $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_vector();
        test_zero_param();
        test_len_fail();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        idle(2);
        checks++; if (multi != 0) $display("FAIL exclusive_pulses got %0d cycles want 0", multi); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
